// File: rtl/gen_arb_rr_burst_ctrl.sv
// Round-robin burst arbiter.
// One of WID requesters owns the downstream resource for a whole burst.
// The grant is one-hot and registered. A tenure ends on a last beat, when
// the beat cap is reached, or when the owner withdraws its request. Exactly
// one dead IDLE cycle follows every tenure, and re-arbitration happens in
// that cycle, starting from the requester just above the previous owner.
module gen_arb_rr_burst_ctrl #(
    parameter int WID       = 4,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = $clog2(MAX_BURST + 1),
    parameter int IDX_W     = $clog2(WID)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WID-1:0]   rqsts,
    input  logic             xfer,
    input  logic             last,
    output logic [WID-1:0]   grnts,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] owner_idx,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             err
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WID-1:0]   grnts_reg;
    logic             gnt_vld_reg;
    logic [IDX_W-1:0] owner_idx_reg;
    logic [CNT_W-1:0] beat_cnt_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic             err_reg;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [WID-1:0]   sel_onehot;
    logic             owner_req;
    logic             cap_hit;
    logic             tenure_end;
    logic             err_cond;

    // Rotating-priority pick: first requester after the pointer, with wrap.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= WID; i++) begin
            cand     = (int'(ptr_reg) + i) % WID;
            cand_idx = IDX_W'(cand);
            if (!sel_found && rqsts[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Decode the selected index into the one-hot grant pattern.
    generate
        for (genvar gi = 0; gi < WID; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel_idx == IDX_W'(gi));
        end
    endgenerate

    // The owner's request is looked up from the registered index, so
    // other requesters can never pre-empt the current tenure.
    assign owner_req  = rqsts[owner_idx_reg];
    assign cap_hit    = (beat_cnt_reg == CNT_W'(MAX_BURST - 1));
    assign tenure_end = (xfer && last) || (xfer && cap_hit) || !owner_req;
    // A beat with no owner, or a last flag with no beat, is a protocol error.
    assign err_cond   = (state_reg == IDLE) ? xfer : (last && !xfer);

    // Arbitration FSM with registered grant, owner, beat counter and error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grnts_reg     <= '0;
            gnt_vld_reg   <= 1'b0;
            owner_idx_reg <= '0;
            beat_cnt_reg  <= '0;
            ptr_reg       <= IDX_W'(WID - 1);
            err_reg       <= 1'b0;
        end else begin
            err_reg <= err_reg | err_cond;
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        state_reg     <= OWN;
                        grnts_reg     <= sel_onehot;
                        gnt_vld_reg   <= 1'b1;
                        owner_idx_reg <= sel_idx;
                        beat_cnt_reg  <= '0;
                    end
                end
                OWN: begin
                    if (tenure_end) begin
                        state_reg    <= IDLE;
                        grnts_reg    <= '0;
                        gnt_vld_reg  <= 1'b0;
                        ptr_reg      <= owner_idx_reg;
                        beat_cnt_reg <= '0;
                    end else if (xfer) begin
                        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    grnts_reg   <= '0;
                    gnt_vld_reg <= 1'b0;
                end
            endcase
        end
    end

    assign grnts     = grnts_reg;
    assign gnt_vld   = gnt_vld_reg;
    assign owner_idx = owner_idx_reg;
    assign beat_cnt  = beat_cnt_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_gen_arb_rr_burst_ctrl.sv
// Testbench for gen_arb_rr_burst_ctrl (WID=4, MAX_BURST=8).
// Expected owners are queued when the stimulus requests them. A monitor
// pops an entry on every new grant and compares it. The stimulus also
// checks cycle-exact values such as beat counts, dead cycles and err.
module tb_gen_arb_rr_burst_ctrl;

    localparam int WID       = 4;
    localparam int MAX_BURST = 8;
    localparam int CNT_W     = $clog2(MAX_BURST + 1);
    localparam int IDX_W     = $clog2(WID);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WID-1:0]   rqsts;
    logic             xfer;
    logic             last;
    logic [WID-1:0]   grnts;
    logic             gnt_vld;
    logic [IDX_W-1:0] owner_idx;
    logic [CNT_W-1:0] beat_cnt;
    logic             err;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic prev_vld = 1'b0;

    gen_arb_rr_burst_ctrl #(.WID(WID), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rqsts     (rqsts),
        .xfer      (xfer),
        .last      (last),
        .grnts     (grnts),
        .gnt_vld   (gnt_vld),
        .owner_idx (owner_idx),
        .beat_cnt  (beat_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endfunction

    // Advance one clock; inputs are driven and outputs read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Monitor: one scoreboard comparison per newly presented grant.
    initial begin
        forever begin
            @(negedge clk);
            if (gnt_vld && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 32'(grnts), 32'(0));
                end else begin
                    int k;
                    logic [WID-1:0] oh;
                    k  = exp_q.pop_front();
                    oh = WID'(1) << k;
                    chk("sb_owner", 32'(owner_idx), 32'(k));
                    chk("sb_grnts", 32'(grnts), 32'(oh));
                end
            end
            prev_vld = gnt_vld;
        end
    end

    initial begin
        rst_n = 1'b0;
        rqsts = '0;
        xfer  = 1'b0;
        last  = 1'b0;
        step();
        do_reset();
        chk("rst_grnts", 32'(grnts), 32'(0));
        chk("rst_vld", 32'(gnt_vld), 32'(0));
        chk("rst_owner", 32'(owner_idx), 32'(0));
        chk("rst_cnt", 32'(beat_cnt), 32'(0));
        chk("rst_err", 32'(err), 32'(0));

        // Single requester, 3-beat burst ending on last.
        rqsts = 4'b0001;
        exp_q.push_back(0);
        step();
        chk("t1_grnts", 32'(grnts), 32'(4'b0001));
        chk("t1_owner", 32'(owner_idx), 32'(0));
        xfer = 1'b1;
        step();
        step();
        chk("t1_cnt2", 32'(beat_cnt), 32'(2));
        last = 1'b1;
        step();
        chk("t1_end_grnts", 32'(grnts), 32'(0));
        chk("t1_end_cnt", 32'(beat_cnt), 32'(0));
        xfer  = 1'b0;
        last  = 1'b0;
        rqsts = '0;
        step();
        chk("t1_stay_idle", 32'(gnt_vld), 32'(0));

        // All requesting, single-beat tenures: order 0,1,2,3,0 with dead cycles.
        do_reset();
        rqsts = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int k;
            k = n % WID;
            exp_q.push_back(k);
            step();
            chk("t2_grant", 32'(grnts), 32'(4'b0001 << k));
            xfer = 1'b1;
            last = 1'b1;
            step();
            chk("t2_dead", 32'(grnts), 32'(0));
            xfer = 1'b0;
            last = 1'b0;
        end
        rqsts = '0;
        step();

        // Burst cap: owner 0 streams 8 beats, then requester 1 follows.
        do_reset();
        rqsts = 4'b0011;
        exp_q.push_back(0);
        step();
        xfer = 1'b1;
        for (int b = 0; b < MAX_BURST; b++) begin
            chk("t3_cnt", 32'(beat_cnt), 32'(b));
            chk("t3_hold", 32'(grnts), 32'(4'b0001));
            step();
        end
        chk("t3_cap_grnts", 32'(grnts), 32'(0));
        chk("t3_cap_cnt", 32'(beat_cnt), 32'(0));
        xfer = 1'b0;
        exp_q.push_back(1);
        step();
        chk("t3_next", 32'(grnts), 32'(4'b0010));
        rqsts = '0;
        step();
        chk("t3_release", 32'(grnts), 32'(0));

        // Owner 2 withdraws mid-burst; requester 3 is next.
        rqsts = 4'b1100;
        exp_q.push_back(2);
        step();
        chk("t4_grant2", 32'(grnts), 32'(4'b0100));
        xfer = 1'b1;
        step();
        xfer  = 1'b0;
        rqsts = 4'b1000;
        exp_q.push_back(3);
        step();
        chk("t4_drop_grnts", 32'(grnts), 32'(0));
        chk("t4_drop_cnt", 32'(beat_cnt), 32'(0));
        step();
        chk("t4_grant3", 32'(grnts), 32'(4'b1000));
        rqsts = '0;
        step();

        // xfer while idle sets a sticky error.
        chk("t5_err_before", 32'(err), 32'(0));
        xfer = 1'b1;
        step();
        xfer = 1'b0;
        chk("t5_err_set", 32'(err), 32'(1));
        rqsts = 4'b0001;
        exp_q.push_back(0);
        step();
        xfer = 1'b1;
        last = 1'b1;
        step();
        xfer  = 1'b0;
        last  = 1'b0;
        rqsts = '0;
        step();
        chk("t5_err_sticky", 32'(err), 32'(1));

        // Reset mid-tenure with beat_cnt=5; index 0 wins afterwards.
        rqsts = 4'b0100;
        exp_q.push_back(2);
        step();
        xfer = 1'b1;
        repeat (5) step();
        chk("t6_cnt5", 32'(beat_cnt), 32'(5));
        xfer  = 1'b0;
        rst_n = 1'b0;
        rqsts = 4'b0101;
        step();
        rst_n = 1'b1;
        chk("t6_rst_grnts", 32'(grnts), 32'(0));
        chk("t6_rst_cnt", 32'(beat_cnt), 32'(0));
        chk("t6_rst_err", 32'(err), 32'(0));
        exp_q.push_back(0);
        step();
        chk("t6_grant0", 32'(grnts), 32'(4'b0001));

        // last without xfer in OWN flags an error but keeps the grant.
        last = 1'b1;
        step();
        last = 1'b0;
        chk("t7_err", 32'(err), 32'(1));
        chk("t7_hold", 32'(grnts), 32'(4'b0001));
        rqsts = '0;
        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
